bch_syndrome_par: RTL and testbench

Parametrised parallel syndrome calculator for the binary BCH decoder. Consumes a received codeword P bits per cycle, highest-degree coefficient first, and produces all 2T syndromes S_j = r(α^j), j = 1..2T, over GF(2^M). Sits between the input framing logic and the key-equation (Euclidean) solver. Generalises the fixed 32-bit, t=8, BCH(8191,8087) calculator to any M/N/P/T, adding a valid/ready handshake on both sides and a zero-syndrome flag.

---
 rtl/bch_syn_pkg.sv | 66 ++++++
 rtl/bch_syn_lane.sv | 54 +++++
 rtl/bch_syndrome_par.sv | 126 ++++++++++++
 tb/tb_bch_syndrome_par.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bch_syn_pkg.sv
// Shared GF(2^M) arithmetic, framing helpers and FSM state type for the
// parallel BCH syndrome calculator. Field routines work on a GF_W-bit
// container so one set of functions serves every M/PRIM_POLY choice.
package bch_syn_pkg;

  localparam int unsigned GF_W = 32;

  typedef enum logic [1:0] {ACC, FIN, HOLD} syn_state_t;

  // Multiply by x, reducing with the primitive polynomial (x^m term included).
  function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] a,
                                               input int unsigned m,
                                               input logic [GF_W-1:0] poly);
    logic [GF_W-1:0] r;
    r = a << 1;
    if (r[m]) r = r ^ poly;
    return r;
  endfunction

  // Shift-and-add GF multiply, MSB of b first.
  function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                             input logic [GF_W-1:0] b,
                                             input int unsigned m,
                                             input logic [GF_W-1:0] poly);
    logic [GF_W-1:0] r;
    r = '0;
    for (int unsigned i = m; i > 0; i--) begin
      r = gf_xtime(r, m, poly);
      if (b[i-1]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [GF_W-1:0] gf_sq(input logic [GF_W-1:0] a,
                                            input int unsigned m,
                                            input logic [GF_W-1:0] poly);
    return gf_mul(a, a, m, poly);
  endfunction

  // alpha^e by square-and-multiply so elaboration loops stay short.
  function automatic logic [GF_W-1:0] gf_alpha_pow(input int unsigned e,
                                                   input int unsigned m,
                                                   input logic [GF_W-1:0] poly);
    logic [GF_W-1:0] r;
    logic [GF_W-1:0] b;
    int unsigned     ex;
    ex = e % ((32'd1 << m) - 32'd1);
    r  = GF_W'(1);
    b  = GF_W'(2);
    for (int unsigned i = 0; i < 32; i++) begin
      if (ex[0]) r = gf_mul(r, b, m, poly);
      b  = gf_mul(b, b, m, poly);
      ex = ex >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned calc_beats(input int unsigned n, input int unsigned p);
    return (n + p - 1) / p;
  endfunction

  function automatic int unsigned calc_pad(input int unsigned n, input int unsigned p);
    return calc_beats(n, p) * p - n;
  endfunction

endpackage

// File: rtl/bch_syn_lane.sv
// One syndrome accumulator for exponent J: folds a P-bit beat into
// acc <- acc*alpha^(J*P) + sum d_k*alpha^(J*k), restarting on the first beat.
module bch_syn_lane
  import bch_syn_pkg::*;
#(
  parameter int unsigned M         = 13,
  parameter int unsigned P         = 32,
  parameter int unsigned J         = 1,
  parameter logic [M:0]  PRIM_POLY = 14'h201B
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         first,
  input  logic [P-1:0] d,
  output logic [M-1:0] acc
);

  localparam logic [GF_W-1:0] POLY = GF_W'(PRIM_POLY);
  localparam logic [M-1:0]    STEP = M'(gf_alpha_pow(J * P, M, POLY));

  function automatic logic [P*M-1:0] mk_tab();
    logic [P*M-1:0] tab;
    tab = '0;
    for (int unsigned k = 0; k < P; k++)
      tab[k*M +: M] = M'(gf_alpha_pow(J * k, M, POLY));
    return tab;
  endfunction

  localparam logic [P*M-1:0] TAB = mk_tab();

  logic [M-1:0] acc_q;
  logic [M-1:0] tree;
  logic [M-1:0] shifted;
  logic [M-1:0] acc_d;

  // XOR tree of per-bit alpha powers plus the constant alpha^(J*P) multiply.
  always_comb begin
    tree = '0;
    for (int unsigned k = 0; k < P; k++)
      if (d[k]) tree = tree ^ TAB[k*M +: M];
    shifted = M'(gf_mul(GF_W'(acc_q), GF_W'(STEP), M, POLY));
    acc_d   = (first ? '0 : shifted) ^ tree;
  end

  // Accumulator register, updated only on accepted beats.
  always_ff @(posedge clk) begin
    if (reset)   acc_q <= '0;
    else if (en) acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/bch_syndrome_par.sv
// Parallel BCH syndrome calculator: P bits/beat, highest degree first,
// produces S_1..S_2T over GF(2^M) with valid/ready on both sides.
// Optional macro BCH_SYN_EVEN_SQUARE_EN: build only odd lanes and derive
// even syndromes as S_2i = S_i^2 when the result is captured.
module bch_syndrome_par
  import bch_syn_pkg::*;
#(
  parameter int unsigned M         = 13,
  parameter int unsigned N         = 8191,
  parameter int unsigned P         = 32,
  parameter int unsigned T         = 8,
  parameter logic [M:0]  PRIM_POLY = 14'h201B
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [P-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2*T*M-1:0] syn,
  output logic             syn_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned     BEATS = calc_beats(N, P);
  localparam int unsigned     PAD   = calc_pad(N, P);
  localparam int unsigned     CW    = $clog2(BEATS + 1);
  localparam logic [GF_W-1:0] POLY  = GF_W'(PRIM_POLY);
  localparam logic [P-1:0]    FIRST_MASK = {P{1'b1}} >> PAD;

`ifdef BCH_SYN_EVEN_SQUARE_EN
  localparam int unsigned NL = T;
`else
  localparam int unsigned NL = 2 * T;
`endif

  syn_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             first, last, accept;
  logic [P-1:0]     d;
  logic [M-1:0]     lane_acc [NL];
  logic [2*T*M-1:0] syn_d, syn_q;
  logic             syn_zero_q;

  assign first  = (cnt_q == '0);
  assign last   = (cnt_q == CW'(BEATS - 1));
  assign accept = in_valid && in_ready;
  assign d      = first ? (in_data & FIRST_MASK) : in_data;

  for (genvar l = 0; l < NL; l++) begin : g_lane
`ifdef BCH_SYN_EVEN_SQUARE_EN
    localparam int unsigned J = 2 * l + 1;
`else
    localparam int unsigned J = l + 1;
`endif
    bch_syn_lane #(
      .M(M), .P(P), .J(J), .PRIM_POLY(PRIM_POLY)
    ) u_lane (
      .clk(clk), .reset(reset), .en(accept), .first(first), .d(d),
      .acc(lane_acc[l])
    );
  end

  // Assemble all 2T syndromes from the lanes (squaring chain when enabled).
  always_comb begin
    logic [M-1:0] s [2*T];
    for (int unsigned j = 1; j <= 2 * T; j++) begin
`ifdef BCH_SYN_EVEN_SQUARE_EN
      // Even index j reads s[j/2-1], always filled earlier in this loop.
      if (j % 2 == 1) s[j-1] = lane_acc[(j-1)/2];
      else            s[j-1] = M'(gf_sq(GF_W'(s[j/2-1]), M, POLY));
`else
      s[j-1] = lane_acc[j-1];
`endif
    end
    syn_d = '0;
    for (int unsigned j = 0; j < 2 * T; j++)
      syn_d[j*M +: M] = s[j];
  end

  // Beat counter within a codeword; wraps on the last accepted beat.
  always_ff @(posedge clk) begin
    if (reset)       cnt_q <= '0;
    else if (accept) cnt_q <= last ? '0 : cnt_q + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ACC;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs, decoded from state only.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && last) state_d = FIN;
      end
      FIN:  state_d = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  // Result capture in FIN; held stable through HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      syn_q      <= '0;
      syn_zero_q <= 1'b0;
    end else if (state_q == FIN) begin
      syn_q      <= syn_d;
      syn_zero_q <= (syn_d == '0);
    end
  end

  assign syn      = syn_q;
  assign syn_zero = syn_zero_q;

endmodule

// File: tb/tb_bch_syndrome_par.sv
// Directed bench for bch_syndrome_par at default parameters
// (M=13, N=8191, P=32, T=8: 256 beats, 1 pad bit).
module tb_bch_syndrome_par;

  localparam int unsigned M = 13;
  localparam int unsigned T = 8;
  localparam int unsigned P = 32;
  localparam int unsigned BEATS = 256;

  logic             clk;
  logic             reset;
  logic [P-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [2*T*M-1:0] syn;
  logic             syn_zero;
  logic             out_valid;
  logic             out_ready;

  int checks = 0;
  int errors = 0;

  logic [P-1:0]     cw [BEATS];
  logic [M-1:0]     a_pow [2*T];
  logic [2*T*M-1:0] held;

  bch_syndrome_par dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .syn(syn), .syn_zero(syn_zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*T*M-1:0] syn_all(input logic [M-1:0] v);
    logic [2*T*M-1:0] r;
    for (int j = 0; j < 2 * T; j++) r[j*M +: M] = v;
    return r;
  endfunction

  function automatic logic [2*T*M-1:0] syn_pow1();
    logic [2*T*M-1:0] r;
    for (int j = 0; j < 2 * T; j++) r[j*M +: M] = a_pow[j];
    return r;
  endfunction

  task automatic clear_cw();
    for (int i = 0; i < BEATS; i++) cw[i] = '0;
  endtask

  // Degree d lives in beat BEATS-1-d/32, bit d%32.
  task automatic set_deg(input int d);
    cw[BEATS - 1 - d / P][d % P] = 1'b1;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      in_data  = cw[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, out_valid, 1'b1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, out_valid, 1'b0);
    check({tag, "_iready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    a_pow[0]  = 13'h0002; a_pow[1]  = 13'h0004; a_pow[2]  = 13'h0008; a_pow[3]  = 13'h0010;
    a_pow[4]  = 13'h0020; a_pow[5]  = 13'h0040; a_pow[6]  = 13'h0080; a_pow[7]  = 13'h0100;
    a_pow[8]  = 13'h0200; a_pow[9]  = 13'h0400; a_pow[10] = 13'h0800; a_pow[11] = 13'h1000;
    a_pow[12] = 13'h001B; a_pow[13] = 13'h0036; a_pow[14] = 13'h006C; a_pow[15] = 13'h00D8;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_syn", syn, '0);
    check("rst_syn_zero", syn_zero, 1'b0);

    // All-zero codeword, latency check across FIN.
    clear_cw();
    send(BEATS);
    check("zero_fin_ovalid", out_valid, 1'b0);
    check("zero_fin_iready", in_ready, 1'b0);
    @(posedge clk); #1;
    check("zero_hold_ovalid", out_valid, 1'b1);
    check("zero_syn", syn, '0);
    check("zero_flag", syn_zero, 1'b1);
    consume("zero");

    // Single error at degree 0: every S_j = 1.
    clear_cw();
    set_deg(0);
    send(BEATS);
    wait_valid("deg0_wait");
    check("deg0_syn", syn, syn_all(13'h0001));
    check("deg0_flag", syn_zero, 1'b0);
    consume("deg0");

    // Single error at degree 1: S_j = alpha^j.
    clear_cw();
    set_deg(1);
    send(BEATS);
    wait_valid("deg1_wait");
    check("deg1_syn", syn, syn_pow1());
    check("deg1_flag", syn_zero, 1'b0);
    consume("deg1");

    // Same word with the pad bit of the first beat set: result unchanged.
    cw[0][P-1] = 1'b1;
    send(BEATS);
    wait_valid("pad_wait");
    check("pad_syn", syn, syn_pow1());
    consume("pad");

    // Top degree N-1: S1 = alpha^-1, S2 = alpha^-2.
    clear_cw();
    set_deg(8190);
    send(BEATS);
    wait_valid("top_wait");
    check("top_s1", syn[M-1:0], 13'h100D);
    check("top_s2", syn[2*M-1:M], 13'h180B);
    check("top_flag", syn_zero, 1'b0);
    consume("top");

    // Errors at degrees 0 and 1, then back-pressure with a pending beat.
    clear_cw();
    set_deg(0);
    set_deg(1);
    send(BEATS);
    wait_valid("bp_wait");
    check("bp_syn", syn, syn_pow1() ^ syn_all(13'h0001));
    held = syn;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_stable", syn, held);
      check("bp_iready", in_ready, 1'b0);
      check("bp_ovalid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    in_data  = '0;
    consume("bp");

    // Next word must start clean: no stray beats taken during HOLD.
    clear_cw();
    set_deg(0);
    send(BEATS);
    wait_valid("post_bp_wait");
    check("post_bp_syn", syn, syn_all(13'h0001));
    consume("post_bp");

    // Abort after 100 random beats, then a degree-0 word.
    for (int i = 0; i < BEATS; i++) cw[i] = $urandom;
    send(100);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_iready", in_ready, 1'b1);
    check("abort_ovalid", out_valid, 1'b0);
    clear_cw();
    set_deg(0);
    send(BEATS);
    wait_valid("abort_wait");
    check("abort_syn", syn, syn_all(13'h0001));
    check("abort_flag", syn_zero, 1'b0);
    consume("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
